// File: rtl/conv_pkg.sv
// conv_pkg: shared types and constants for the conv_engine block.
package conv_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CWR, S_PRD, S_PWR, S_FRD, S_FWR, S_DONE
  } state_t;

  // csel[3:2] layer codes
  localparam logic [1:0] LYR_NONE = 2'd0;
  localparam logic [1:0] LYR_L0   = 2'd1;
  localparam logic [1:0] LYR_L1   = 2'd2;
  localparam logic [1:0] LYR_L2   = 2'd3;

  // 3x3 taps in raster order: dy outer, dx inner
  localparam int NTAPS    = 9;
  localparam int BIAS_IDX = 9;
  localparam int TAP_DY [9] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
  localparam int TAP_DX [9] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};

  // post(): accumulator carries ACC_GUARD bits above the 2*DW product
  localparam int ACC_GUARD = 4;

endpackage

// File: rtl/conv_engine_if.sv
// conv_engine_if: start/busy handshake, image port, weight port and layer memory bus.
interface conv_engine_if #(
  parameter int AW = 12,
  parameter int DW = 20
);
  logic          ready;
  logic          busy;
  logic [AW-1:0] iaddr;
  logic [DW-1:0] idata;
  logic          wld;
  logic [1:0]    wsel;
  logic [3:0]    widx;
  logic [DW-1:0] wdata;
  logic          cwr;
  logic [AW-1:0] caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic [DW-1:0] cdata_rd;
  logic [3:0]    csel;

  modport master (
    input  ready, idata, wld, wsel, widx, wdata, cdata_rd,
    output busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
  );

  modport slave (
    output ready, idata, wld, wsel, widx, wdata, cdata_rd,
    input  busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
  );
endinterface

// File: rtl/conv_mac_post.sv
// conv_mac_post: one kernel's weights/bias, MAC accumulator and
// bias + ReLU + round-half-up + saturate output stage.
module conv_mac_post import conv_pkg::*; #(
  parameter int DW   = 20,
  parameter int FRAC = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          w_we,
  input  logic [3:0]    widx,
  input  logic [DW-1:0] wdata,
  input  logic          mac_en,
  input  logic          mac_first,
  input  logic [3:0]    tap,
  input  logic [DW-1:0] pixel,
  output logic [DW-1:0] post_out
);
  localparam int ACC_W = 2*DW + ACC_GUARD;
  localparam logic [ACC_W-1:0] MAXV = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};

  logic signed [DW-1:0]    w_q [10];
  logic signed [DW-1:0]    w_d [10];
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] sum;
  logic [ACC_W-1:0]        half, rsh;

  // weight/bias load; slots above the bias are ignored
  always_comb begin
    w_d = w_q;
    if (w_we && widx <= 4'd9) w_d[widx] = wdata;
  end

  // multiply-accumulate; the first tap of a pixel restarts the sum
  always_comb begin
    prod  = w_q[tap] * $signed(pixel);
    acc_d = acc_q;
    if (mac_en)
      acc_d = (mac_first ? '0 : acc_q) + {{ACC_GUARD{prod[2*DW-1]}}, prod};
  end

  // bias, ReLU, round (carry in the bit just below the point), saturate
  always_comb begin
    sum      = acc_q + ({{(ACC_W-DW){w_q[BIAS_IDX][DW-1]}}, w_q[BIAS_IDX]} << FRAC);
    half     = sum >> (FRAC-1);
    rsh      = (half + ACC_W'(1)) >> 1;
    post_out = '0;
    if (!sum[ACC_W-1]) post_out = (rsh > MAXV) ? MAXV[DW-1:0] : rsh[DW-1:0];
  end

  // weight and accumulator registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 10; i++) w_q[i] <= '0;
      acc_q <= '0;
    end else begin
      w_q   <= w_d;
      acc_q <= acc_d;
    end
  end
endmodule

// File: rtl/conv_engine.sv
// conv_engine: NUM_K 3x3 convolutions -> L0, 2x2 max-pool -> L1 and,
// with CONV_FLATTEN_EN defined, kernel-interleaved flatten -> L2.
module conv_engine import conv_pkg::*; #(
  parameter int IMG_W = 64,
  parameter int NUM_K = 2,
  parameter int DW    = 20,
  parameter int FRAC  = 16
) (
  input logic         clk,
  input logic         reset,
  conv_engine_if.master bus
);
  localparam int LW  = $clog2(IMG_W);
  localparam int AW  = 2*LW;
  localparam int PAW = AW - 2;
  localparam logic [AW-1:0]  LAST_PIX  = '1;
  localparam logic [PAW-1:0] LAST_POOL = '1;
  localparam logic [1:0]     LAST_K    = 2'(NUM_K-1);

  state_t         state_q, state_d;
  logic [AW-1:0]  pix_q, pix_d;
  logic [3:0]     tap_q, tap_d;
  logic [1:0]     k_q, k_d, j_q, j_d;
  logic [PAW-1:0] pidx_q, pidx_d;
  logic [DW-1:0]  max_q, max_d;
`ifdef CONV_FLATTEN_EN
  logic [DW-1:0]  fdat_q, fdat_d;
`endif
  int             nr, nc;
  logic           nbr_ok, mac_en, mac_first;
  logic [AW-1:0]  nbr_addr;
  logic [DW-1:0]  pix_in;
  logic [DW-1:0]  post_v [4];

  assign mac_en    = (state_q == S_FETCH);
  assign mac_first = (tap_q == 4'd0);

  // neighbour address and zero padding outside the image
  always_comb begin
    nr       = int'(pix_q[AW-1:LW]) + TAP_DY[tap_q];
    nc       = int'(pix_q[LW-1:0]) + TAP_DX[tap_q];
    nbr_ok   = (nr >= 0) && (nr < IMG_W) && (nc >= 0) && (nc < IMG_W);
    nbr_addr = AW'(int'(pix_q) + TAP_DY[tap_q]*IMG_W + TAP_DX[tap_q]);
    pix_in   = nbr_ok ? bus.idata : '0;
  end

  for (genvar g = 0; g < 4; g++) begin : g_k
    if (g < NUM_K) begin : g_mac
      conv_mac_post #(.DW(DW), .FRAC(FRAC)) u_mac (
        .clk       (clk),
        .reset     (reset),
        .w_we      (state_q == S_IDLE && bus.wld && bus.wsel == 2'(g)),
        .widx      (bus.widx),
        .wdata     (bus.wdata),
        .mac_en    (mac_en),
        .mac_first (mac_first),
        .tap       (tap_q),
        .pixel     (pix_in),
        .post_out  (post_v[g])
      );
    end else begin : g_none
      assign post_v[g] = '0;
    end
  end

  // sequencing: conv per pixel, pool per kernel, then optional flatten
  always_comb begin
    state_d = state_q; pix_d = pix_q; tap_d = tap_q; k_d = k_q; j_d = j_q;
    pidx_d = pidx_q; max_d = max_q;
`ifdef CONV_FLATTEN_EN
    fdat_d = fdat_q;
`endif
    bus.busy = !(state_q == S_IDLE || state_q == S_DONE);
    bus.iaddr = '0; bus.cwr = 1'b0; bus.caddr_wr = '0; bus.cdata_wr = '0;
    bus.crd = 1'b0; bus.caddr_rd = '0; bus.csel = {LYR_NONE, 2'd0};
    case (state_q)
      S_IDLE: if (bus.ready) begin
        state_d = S_FETCH; pix_d = '0; tap_d = '0; k_d = '0;
      end
      S_FETCH: begin
        bus.iaddr = nbr_addr;
        tap_d = tap_q + 4'd1;
        if (tap_q == 4'd8) begin state_d = S_CWR; tap_d = '0; k_d = '0; end
      end
      S_CWR: begin
        bus.cwr = 1'b1; bus.csel = {LYR_L0, k_q};
        bus.caddr_wr = pix_q; bus.cdata_wr = post_v[k_q];
        k_d = k_q + 2'd1;
        if (k_q == LAST_K) begin
          k_d = '0;
          if (pix_q == LAST_PIX) begin state_d = S_PRD; pidx_d = '0; j_d = '0; end
          else begin state_d = S_FETCH; pix_d = pix_q + 1'b1; end
        end
      end
      S_PRD: begin
        // window offsets {0, 1, W, W+1} fall out of j's two bits
        bus.crd = 1'b1; bus.csel = {LYR_L0, k_q};
        bus.caddr_rd = {pidx_q[PAW-1:LW-1], j_q[1], pidx_q[LW-2:0], j_q[0]};
        if (j_q == 2'd0 || bus.cdata_rd > max_q) max_d = bus.cdata_rd;
        j_d = j_q + 2'd1;
        if (j_q == 2'd3) state_d = S_PWR;
      end
      S_PWR: begin
        bus.cwr = 1'b1; bus.csel = {LYR_L1, k_q};
        bus.caddr_wr = AW'(pidx_q); bus.cdata_wr = max_q;
        state_d = S_PRD; pidx_d = pidx_q + 1'b1;
        if (pidx_q == LAST_POOL) begin
          pidx_d = '0;
          k_d = k_q + 2'd1;
          if (k_q == LAST_K) begin
            k_d = '0;
`ifdef CONV_FLATTEN_EN
            state_d = S_FRD;
`else
            state_d = S_DONE;
`endif
          end
        end
      end
`ifdef CONV_FLATTEN_EN
      S_FRD: begin
        bus.crd = 1'b1; bus.csel = {LYR_L1, k_q};
        bus.caddr_rd = AW'(pidx_q); fdat_d = bus.cdata_rd;
        state_d = S_FWR;
      end
      S_FWR: begin
        bus.cwr = 1'b1; bus.csel = {LYR_L2, 2'd0};
        bus.caddr_wr = AW'(int'(pidx_q) * NUM_K + int'(k_q));
        bus.cdata_wr = fdat_q;
        state_d = S_FRD; k_d = k_q + 2'd1;
        if (k_q == LAST_K) begin
          k_d = '0; pidx_d = pidx_q + 1'b1;
          if (pidx_q == LAST_POOL) begin state_d = S_DONE; pidx_d = '0; end
        end
      end
`endif
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // control registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE; pix_q <= '0; tap_q <= '0; k_q <= '0; j_q <= '0;
      pidx_q <= '0; max_q <= '0;
`ifdef CONV_FLATTEN_EN
      fdat_q <= '0;
`endif
    end else begin
      state_q <= state_d; pix_q <= pix_d; tap_q <= tap_d; k_q <= k_d; j_q <= j_d;
      pidx_q <= pidx_d; max_q <= max_d;
`ifdef CONV_FLATTEN_EN
      fdat_q <= fdat_d;
`endif
    end
  end
endmodule

// File: tb/tb_conv_engine.sv
// tb_conv_engine: 8x8 image, two kernels. A reference model computes L0/L1/L2
// from image and weights; one negedge process checks every layer write.
module tb_conv_engine;
  localparam int W = 8, K = 2, DW = 20, FRAC = 16, AW = 6;
  localparam int N = W*W, PWD = W/2, PN = PWD*PWD;
  localparam longint MAXV = (longint'(1) << (DW-1)) - 1;
`ifdef CONV_FLATTEN_EN
  localparam int EXP_LEN = N*(9+K) + PN*K*5 + PN*K*2;
  localparam int EXP_WR  = N*K + PN*K + PN*K;
`else
  localparam int EXP_LEN = N*(9+K) + PN*K*5;
  localparam int EXP_WR  = N*K + PN*K;
`endif

  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  conv_engine_if #(.AW(AW), .DW(DW)) bus();
  conv_engine #(.IMG_W(W), .NUM_K(K), .DW(DW), .FRAC(FRAC)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  logic [DW-1:0] img [N];
  logic [DW-1:0] l0 [K][N];
  logic [DW-1:0] l1 [K][PN];
  logic [DW-1:0] l2 [K*PN];
  logic [DW-1:0] sv1 [K][PN];
  longint wt [K][10];
  longint exp_l0 [K][N];
  longint exp_l1 [K][PN];
  longint exp_l2 [K*PN];

  int chk_cnt = 0, pass_cnt = 0;
  int busy_cyc, first_cwr, wr_cnt;
  bit run_on = 1'b0;
  bit mk;

  assign bus.idata = img[bus.iaddr];
  always_comb begin
    bus.cdata_rd = '0;
    if (bus.csel[3:2] == 2'd1) bus.cdata_rd = l0[bus.csel[0]][bus.caddr_rd];
    else if (bus.csel[3:2] == 2'd2) bus.cdata_rd = l1[bus.csel[0]][bus.caddr_rd[3:0]];
  end

  task automatic check(input string nm, input longint act, input longint exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic longint sx(input logic [DW-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint post(input longint s);
    longint r;
    if (s < 0) return 0;
    r = (s >>> FRAC) + ((s >>> (FRAC-1)) & 1);
    return (r > MAXV) ? MAXV : r;
  endfunction

  // reference: plain 2-D convolution, 2x2 max, interleave
  task automatic build_model();
    for (int k = 0; k < K; k++)
      for (int r = 0; r < W; r++)
        for (int c = 0; c < W; c++) begin
          longint s = wt[k][9] * (longint'(1) << FRAC);
          for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
              if (r+dy >= 0 && r+dy < W && c+dx >= 0 && c+dx < W)
                s += wt[k][(dy+1)*3 + dx + 1] * sx(img[(r+dy)*W + c + dx]);
          exp_l0[k][r*W + c] = post(s);
        end
    for (int k = 0; k < K; k++)
      for (int pr = 0; pr < PWD; pr++)
        for (int pc = 0; pc < PWD; pc++) begin
          longint m = 0;
          for (int a = 0; a < 2; a++)
            for (int b = 0; b < 2; b++)
              if (exp_l0[k][(2*pr+a)*W + 2*pc + b] > m) m = exp_l0[k][(2*pr+a)*W + 2*pc + b];
          exp_l1[k][pr*PWD + pc] = m;
          exp_l2[(pr*PWD + pc)*K + k] = m;
        end
  endtask

  // the compare process: every write during a run is checked against the model
  always @(negedge clk) begin
    if (run_on && !reset) begin
      if (bus.busy) busy_cyc++;
      if (bus.cwr && first_cwr < 0) first_cwr = busy_cyc;
      check("cwr_crd_excl", longint'(bus.cwr & bus.crd), 0);
      if (bus.cwr) begin
        wr_cnt++;
        mk = bus.csel[0];
        case (bus.csel[3:2])
          2'd1: begin
            check("l0_wr", bus.cdata_wr, exp_l0[mk][bus.caddr_wr]);
            check("l0_ksel", bus.csel[1], 0);
            l0[mk][bus.caddr_wr] = bus.cdata_wr;
          end
          2'd2: begin
            check("l1_wr", bus.cdata_wr, exp_l1[mk][bus.caddr_wr[3:0]]);
            check("l1_addr_hi", bus.caddr_wr[5:4], 0);
            l1[mk][bus.caddr_wr[3:0]] = bus.cdata_wr;
          end
`ifdef CONV_FLATTEN_EN
          2'd3: begin
            check("l2_wr", bus.cdata_wr, exp_l2[bus.caddr_wr[4:0]]);
            check("l2_csel_k", bus.csel[1:0], 0);
            l2[bus.caddr_wr[4:0]] = bus.cdata_wr;
          end
`endif
          default: check("cwr_layer", bus.csel[3:2], 1);
        endcase
      end
    end
  end

  task automatic load_w(input int k, input int idx, input logic [DW-1:0] v);
    @(negedge clk);
    bus.wld = 1'b1; bus.wsel = 2'(k); bus.widx = 4'(idx); bus.wdata = v;
    @(negedge clk);
    bus.wld = 1'b0;
    wt[k][idx] = sx(v);
  endtask

  task automatic set_kernel(input int k, input logic [DW-1:0] ctr,
                            input logic [DW-1:0] oth, input logic [DW-1:0] bias);
    for (int i = 0; i < 10; i++)
      load_w(k, i, (i == 4) ? ctr : (i == 9) ? bias : oth);
  endtask

  task automatic fill_img(input logic [DW-1:0] v);
    for (int i = 0; i < N; i++) img[i] = v;
  endtask

  task automatic run(input string tag, input bit noise);
    int cyc;
    build_model();
    busy_cyc = 0; first_cwr = -1; wr_cnt = 0; run_on = 1'b1;
    @(negedge clk) bus.ready = 1'b1;
    @(negedge clk) bus.ready = 1'b0;
    check({tag, "_busy_rise"}, bus.busy, 1);
    cyc = 0;
    while (bus.busy && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (noise && cyc == 100) begin
        bus.ready = 1'b1; bus.wld = 1'b1; bus.wsel = 2'd0; bus.widx = 4'd4;
        bus.wdata = 20'h12345;
      end else if (noise && cyc == 101) begin
        bus.ready = 1'b0; bus.wld = 1'b0;
      end
    end
    check({tag, "_timeout"}, bus.busy, 0);
    check({tag, "_done_quiet"}, {bus.cwr, bus.crd, bus.csel, bus.iaddr}, 0);
    run_on = 1'b0;
    check({tag, "_run_len"}, busy_cyc, EXP_LEN);
    check({tag, "_wr_count"}, wr_cnt, EXP_WR);
    check({tag, "_first_cwr"}, first_cwr, 10);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ready = 1'b0; bus.wld = 1'b0; bus.wsel = '0; bus.widx = '0; bus.wdata = '0;
    for (int k = 0; k < K; k++) for (int i = 0; i < 10; i++) wt[k][i] = 0;
    fill_img('0);
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_strobes", {bus.cwr, bus.crd}, 0);
    check("rst_addrs", {bus.iaddr, bus.caddr_wr, bus.caddr_rd, bus.csel}, 0);
    check("rst_wdata", bus.cdata_wr, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", bus.busy, 0);

    // identity and -1.0 centre kernels on a flat 1.0 image
    load_w(0, 4, 20'h10000);
    load_w(1, 4, 20'hF0000);
    fill_img(20'h10000);
    run("t1", 1'b0);
    check("t1_l0k0", l0[0][27], 'h10000);
    check("t1_l0k1", l0[1][0], 0);
    check("t1_l1k0", l1[0][5], 'h10000);

    // all-ones kernel: 4, 6, 9 neighbours; 9.0 exceeds the 20-bit range
    set_kernel(0, 20'h10000, 20'h10000, 20'h0);
    run("t2", 1'b0);
    check("t2_model_corner", exp_l0[0][0], 'h40000);
    check("t2_model_edge", exp_l0[0][3], 'h60000);
    check("t2_model_inner", exp_l0[0][9], 'h7FFFF);
    check("t2_dut_edge", l0[0][8], 'h60000);

    // saturation and round-half-up
    set_kernel(0, 20'h7FFFF, 20'h0, 20'h0);
    set_kernel(1, 20'h08000, 20'h0, 20'h0);
    fill_img(20'h7FFFF);
    img[0] = 20'h00001;
    run("t3", 1'b0);
    check("t3_model_sat", exp_l0[0][9], 'h7FFFF);
    check("t3_model_rnd", exp_l0[1][0], 1);
    check("t3_dut_rnd", l0[1][0], 1);

    // pooling window {3,9,5,1}; ready and wld pulsed mid-run must be ignored
    set_kernel(0, 20'h10000, 20'h0, 20'h0);
    set_kernel(1, 20'h10000, 20'h0, 20'h0);
    fill_img('0);
    img[0] = 20'd3; img[1] = 20'd9; img[8] = 20'd5; img[9] = 20'd1; img[6] = 20'h42;
    run("t4", 1'b1);
    check("t4_model_pool", exp_l1[0][0], 9);
    check("t4_dut_pool", l1[0][0], 9);
    check("t4_dut_pool_k1", l1[1][3], 'h42);
`ifdef CONV_FLATTEN_EN
    check("t4_model_l2_7", exp_l2[7], 'h42);
    check("t4_dut_l2_7", l2[7], 'h42);
`endif

    // re-run with the same weights after DONE gives identical results
    for (int k = 0; k < K; k++) for (int i = 0; i < PN; i++) begin
      sv1[k][i] = l1[k][i]; l1[k][i] = '0;
    end
    for (int k = 0; k < K; k++) for (int i = 0; i < N; i++) l0[k][i] = '0;
    run("t5", 1'b0);
    for (int k = 0; k < K; k++) for (int i = 0; i < PN; i += 5)
      check("t5_rerun_l1", l1[k][i], sv1[k][i]);

    // randomized weights, biases and images
    for (int it = 0; it < 3; it++) begin
      for (int k = 0; k < K; k++) for (int i = 0; i < 10; i++)
        load_w(k, i, DW'(int'($urandom_range(0, 'h3FFFF)) - 'h20000));
      for (int i = 0; i < N; i++) img[i] = DW'($urandom);
      run("rnd", 1'b0);
    end

    // reset mid-FETCH aborts and clears weights
    @(negedge clk) bus.ready = 1'b1;
    @(negedge clk) bus.ready = 1'b0;
    repeat (3) @(negedge clk);
    check("midrun_busy_pre", bus.busy, 1);
    reset = 1'b1;
    #1 check("midrun_busy_async", bus.busy, 0);
    @(negedge clk);
    check("midrun_busy_next", bus.busy, 0);
    reset = 1'b0;
    for (int k = 0; k < K; k++) for (int i = 0; i < 10; i++) wt[k][i] = 0;
    for (int i = 0; i < N; i++) img[i] = DW'($urandom_range(1, 'h3FFFF));
    run("t7", 1'b0);
    check("t7_cleared_w", l0[1][20], 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
